// File: rtl/pc_unit_if.sv
// ---------------------------------------------------------------------------
// pc_unit_if
// Bundles the request inputs and state outputs of the program-counter unit.
//   master : control side. Drives the advance strobe, redirect/trap/RAS
//            requests, and observes the PC, epc and RAS state.
//   slave  : pc_unit side. Mirror image of master.
// Signals:
//   increment_en                  advance strobe; nothing changes when 0
//   redirect_valid/redirect_target branch/jump redirect
//   trap_req/trap_vector          trap entry
//   trap_return                   return from trap to epc
//   ras_push/ras_pop              return-address stack requests
//   current_pc, pc_plus4, epc     PC state and sequential successor
//   ras_top/ras_empty/ras_full    RAS state
//   misaligned                    one-cycle pulse: selected target rejected
// ---------------------------------------------------------------------------
interface pc_unit_if #(
   parameter int XLEN = 32
);
   logic            increment_en;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic            trap_req;
   logic [XLEN-1:0] trap_vector;
   logic            trap_return;
   logic            ras_push;
   logic            ras_pop;
   logic [XLEN-1:0] current_pc;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] epc;
   logic [XLEN-1:0] ras_top;
   logic            ras_empty;
   logic            ras_full;
   logic            misaligned;

   modport master (
      output increment_en, redirect_valid, redirect_target,
             trap_req, trap_vector, trap_return, ras_push, ras_pop,
      input  current_pc, pc_plus4, epc, ras_top, ras_empty, ras_full,
             misaligned
   );

   modport slave (
      input  increment_en, redirect_valid, redirect_target,
             trap_req, trap_vector, trap_return, ras_push, ras_pop,
      output current_pc, pc_plus4, epc, ras_top, ras_empty, ras_full,
             misaligned
   );
endinterface

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Architectural program counter with prioritised next-PC selection
// (trap entry > trap return > redirect > sequential), a trap-return register
// and a circular return-address stack. Every state change is gated by
// bus.increment_en.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pc_unit_if.slave: requests in, PC/epc/RAS state out
// ---------------------------------------------------------------------------
module pc_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              RAS_DEPTH    = 4
) (
   input logic        clk,
   input logic        rst_n,
   pc_unit_if.slave   bus
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic [XLEN-1:0]  pc_q;
   logic [XLEN-1:0]  epc_q;
   logic             mis_q;
   logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] top_q;
   logic [CNT_W-1:0] cnt_q;

   logic [XLEN-1:0]  pc_plus4;
   logic [XLEN-1:0]  target;
   logic             nonseq;
   logic             save_epc;
   logic             bad_target;
   logic             ras_is_empty;
   logic             ras_is_full;
   logic             push_only;
   logic             replace_top;
   logic             pop_only;

   // Wraps modulo 2^XLEN by construction.
   assign pc_plus4 = pc_q + XLEN'(4);

   // NOTE: every variable gets a default before the if-chain, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      target   = pc_plus4;
      nonseq   = 1'b0;
      save_epc = 1'b0;
      if (bus.trap_req) begin
         target   = bus.trap_vector;
         nonseq   = 1'b1;
         save_epc = 1'b1;
      end else if (bus.trap_return) begin
         target = epc_q;
         nonseq = 1'b1;
      end else if (bus.redirect_valid) begin
         target = bus.redirect_target;
         nonseq = 1'b1;
      end
   end

   assign bad_target = nonseq && (target[1:0] != 2'b00);

   assign ras_is_empty = (cnt_q == '0);
   assign ras_is_full  = (cnt_q == CNT_W'(RAS_DEPTH));

   // Push+pop on an empty stack degenerates to a plain push; pop on an
   // empty stack is dropped.
   assign push_only   = bus.ras_push && (!bus.ras_pop || ras_is_empty);
   assign replace_top = bus.ras_push && bus.ras_pop && !ras_is_empty;
   assign pop_only    = bus.ras_pop && !bus.ras_push && !ras_is_empty;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_VECTOR;
         epc_q <= '0;
         mis_q <= 1'b0;
         top_q <= '0;
         cnt_q <= '0;
      end else if (bus.increment_en) begin
         mis_q <= bad_target;
         if (!bad_target) begin
            pc_q <= target;
            if (save_epc) epc_q <= pc_q;
         end
         if (push_only) begin
            top_q <= top_q + 1'b1;
            // A full stack wraps and overwrites its oldest entry.
            if (!ras_is_full) cnt_q <= cnt_q + 1'b1;
         end else if (pop_only) begin
            top_q <= top_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
         end
      end else begin
         mis_q <= 1'b0;
      end
   end

   // NOTE: the RAS storage is not reset; ras_top is masked by the count, so
   // stale contents are never visible.
   always_ff @(posedge clk) begin
      if (bus.increment_en) begin
         if (push_only)        ras_mem[top_q + 1'b1] <= pc_plus4;
         else if (replace_top) ras_mem[top_q]        <= pc_plus4;
      end
   end

   assign bus.current_pc = pc_q;
   assign bus.pc_plus4   = pc_plus4;
   assign bus.epc        = epc_q;
   assign bus.ras_top    = ras_is_empty ? '0 : ras_mem[top_q];
   assign bus.ras_empty  = ras_is_empty;
   assign bus.ras_full   = ras_is_full;
   assign bus.misaligned = mis_q;
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit replacing the single-register PC in the RISC-V core. It holds the architectural PC, selects the next PC from sequential, branch/jump redirect, trap entry and trap return sources with fixed priority, and keeps a trap-return register plus a small circular return-address stack (RAS). All updates are gated by the control state machine's advance strobe.

## Interface
- XLEN, 32, PC and target width in bits (≥ 8)
- RESET_VECTOR, 0, PC value loaded on reset (XLEN bits, 4-byte aligned)
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥ 2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- increment_en  in  1  advance strobe from control FSM; no state changes when 0
- redirect_valid  in  1  take redirect_target (branch taken, JAL, JALR)
- redirect_target  in  XLEN  redirect destination
- trap_req  in  1  enter trap
- trap_vector  in  XLEN  trap handler address
- trap_return  in  1  return from trap to epc
- ras_push  in  1  push pc_plus4 (call)
- ras_pop  in  1  drop top entry (return)
- current_pc  out  XLEN  architectural PC (registered)
- pc_plus4  out  XLEN  current_pc + 4, combinational, modulo 2^XLEN
- epc  out  XLEN  saved trap PC (registered)
- ras_top  out  XLEN  top RAS entry; 0 when empty
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- misaligned  out  1  registered one-cycle pulse: selected target rejected

## Operation
- Reset (rst_n=0, asynchronous): current_pc=RESET_VECTOR, epc=0, RAS count=0, ras_top=0, ras_empty=1, ras_full=0, misaligned=0.
- increment_en=0: all registers hold; misaligned clears to 0; all other inputs ignored.
- increment_en=1, next-PC priority (highest first):
  - trap_req: current_pc←trap_vector, epc←current_pc.
  - trap_return: current_pc←epc.
  - redirect_valid: current_pc←redirect_target.
  - otherwise: current_pc←pc_plus4.
- Alignment: if the selected non-sequential target has bits [1:0]≠0, current_pc holds, misaligned=1 for the next cycle, and epc is unchanged. trap_vector is checked too.
- RAS (increment_en=1, acts independently of PC selection; pushed value is pc_plus4 of the pre-update PC):
  - push only: write at top+1 and increment count. When full, overwrite the oldest entry circularly; count stays RAS_DEPTH.
  - pop only: decrement count. Pop when empty is ignored.
  - push and pop together: replace the top entry with pc_plus4 and leave count unchanged. When empty, this is treated as push.
  - trap_req does not touch the RAS.
- Arithmetic: all PC sums are XLEN-bit and wrap silently; 0xFFFF_FFFC + 4 = 0x0000_0000.

## Timing
- Single-cycle: inputs are sampled on the rising clk edge where increment_en=1. current_pc, epc and the RAS update on that edge.
- pc_plus4, ras_top, ras_empty and ras_full are combinational from registered state and are valid in the same cycle as the state change.
- misaligned is asserted in the cycle after the offending edge, for exactly one cycle unless the next advance is also misaligned.
- Reset asserted mid-operation takes effect immediately (asynchronous). Release is synchronous to clk; the first advance after release uses RESET_VECTOR as current_pc.
- No handshake back-pressure: the controller must hold request inputs valid with increment_en for one cycle per event.

## Test plan
- Reset then 3 advances with no requests: current_pc 0x0→0x4→0x8→0xC; epc=0; ras_empty=1.
- At PC 0x10, redirect_valid with target 0x100 and trap_req with vector 0x200 together: PC=0x200, epc=0x10. Then trap_return: PC=0x10.
- redirect_target=0x102: PC holds at its value, misaligned=1 for one cycle, then 0.
- RAS_DEPTH=4, five pushes at PCs 0x0, 0x4, 0x8, 0xC, 0x10: ras_full=1, ras_top=0x14. Four pops return 0x14, 0x10, 0xC, 0x8; after the fourth pop ras_empty=1, and a fifth pop is ignored.
- Push and pop together at PC 0x40 with 2 entries: count stays 2, ras_top=0x44.
- Start at PC 0xFFFF_FFFC and advance: PC=0x0. Assert rst_n low mid-cycle: PC=RESET_VECTOR immediately, without waiting for a clock edge.
